// File: rtl/vx_ecc_scrub_ctrl.sv
// vx_ecc_scrub_ctrl: background SECDED scrubber sharing one cache bank port, cache has priority
module vx_ecc_scrub_ctrl #(
    parameter int NUM_LINES    = 64,
    parameter int ENCODED_BITS = 137,
    parameter int INTERVAL     = 1024,
    parameter int CNT_BITS     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          scrub_now,
    input  logic                          cache_busy,
    input  logic                          cache_wr_valid,
    input  logic [$clog2(NUM_LINES)-1:0]  cache_wr_addr,
    output logic                          mem_req_valid,
    output logic                          mem_req_rw,
    output logic [$clog2(NUM_LINES)-1:0]  mem_req_addr,
    output logic [ENCODED_BITS-1:0]       mem_req_data,
    input  logic                          mem_req_ready,
    input  logic                          mem_rsp_valid,
    input  logic [ENCODED_BITS-1:0]       mem_rsp_data,
    output logic [ENCODED_BITS-1:0]       dec_in,
    input  logic [ENCODED_BITS-1:0]       dec_fixed,
    input  logic                          dec_sbe,
    input  logic                          dec_dbe,
    output logic [CNT_BITS-1:0]           sbe_count,
    output logic [CNT_BITS-1:0]           dbe_count,
    output logic                          dbe_irq,
    output logic [$clog2(NUM_LINES)-1:0]  dbe_addr,
    output logic                          pass_done,
    output logic                          busy
);
    localparam int AW = $clog2(NUM_LINES);
    localparam int TW = INTERVAL > 1 ? $clog2(INTERVAL) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(INTERVAL - 1);
    typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT} state_t;
    state_t                  state;
    logic [AW-1:0]           ptr;
    logic [TW-1:0]           timer;
    logic                    pass_mode;
    logic                    stale;
    logic [ENCODED_BITS-1:0] fix;
    logic                    hit;
    logic                    stale_now;
    logic                    pass_nx;
    assign hit           = cache_wr_valid && cache_wr_addr == ptr;
    assign stale_now     = stale || hit;
    assign pass_nx       = (pass_mode || scrub_now) && !(&ptr);
    assign busy          = state != IDLE && state != WAIT;
    // a write-back is withheld once the cache has rewritten the line under us
    assign mem_req_valid = !cache_busy && (state == RD_REQ || (state == WR_REQ && !stale_now));
    assign mem_req_rw    = state == WR_REQ;
    assign mem_req_addr  = ptr;
    assign mem_req_data  = fix;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            timer     <= '0;
            pass_mode <= 1'b0;
            stale     <= 1'b0;
            fix       <= '0;
            dec_in    <= '0;
            sbe_count <= '0;
            dbe_count <= '0;
            dbe_irq   <= 1'b0;
            dbe_addr  <= '0;
            pass_done <= 1'b0;
        end else begin
            dbe_irq   <= 1'b0;
            pass_done <= 1'b0;
            if (scrub_now && busy) pass_mode <= 1'b1;
            if (hit && state inside {RD_WAIT, CHECK, WR_REQ}) stale <= 1'b1;
            case (state)
                IDLE: begin
                    if (scrub_now) begin
                        state     <= RD_REQ;
                        pass_mode <= 1'b1;
                    end else if (enable) begin
                        state <= WAIT;
                        timer <= '0;
                    end
                end
                WAIT: begin
                    if (scrub_now) begin
                        state     <= RD_REQ;
                        pass_mode <= 1'b1;
                    end else if (!enable) state <= IDLE;
                    else if (timer == T_LAST) state <= RD_REQ;
                    else timer <= timer + 1'b1;
                end
                RD_REQ: if (mem_req_valid && mem_req_ready) state <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        dec_in <= mem_rsp_data;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (dec_dbe) begin
                        dbe_count <= dbe_count + {{(CNT_BITS-1){1'b0}}, ~&dbe_count};
                        dbe_addr  <= ptr;
                        dbe_irq   <= 1'b1;
                        state     <= NEXT;
                    end else if (dec_sbe) begin
                        sbe_count <= sbe_count + {{(CNT_BITS-1){1'b0}}, ~&sbe_count};
                        fix       <= dec_fixed;
                        state     <= stale_now ? NEXT : WR_REQ;
                    end else state <= NEXT;
                end
                WR_REQ: if (stale_now || (mem_req_valid && mem_req_ready)) state <= NEXT;
                NEXT: begin
                    ptr       <= ptr + 1'b1;
                    stale     <= 1'b0;
                    timer     <= '0;
                    pass_done <= &ptr;
                    pass_mode <= pass_nx;
                    state     <= pass_nx ? RD_REQ : enable ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_ecc_scrub_ctrl.sv
// tb_vx_ecc_scrub_ctrl: randomized bank/decoder environment with a transaction-level scrub model
module tb_vx_ecc_scrub_ctrl;
    localparam int N  = 4;
    localparam int EB = 137;
    localparam int IV = 8;
    localparam int CB = 4;
    localparam int CMAX = (1 << CB) - 1;
    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, scrub_now = 1'b0;
    logic          cache_busy = 1'b0, cache_wr_valid = 1'b0;
    logic [1:0]    cache_wr_addr = '0;
    logic          mem_req_valid, mem_req_rw;
    logic [1:0]    mem_req_addr;
    logic [EB-1:0] mem_req_data;
    logic          mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [EB-1:0] mem_rsp_data = '0;
    logic [EB-1:0] dec_in, dec_fixed;
    logic          dec_sbe, dec_dbe;
    logic [CB-1:0] sbe_count, dbe_count;
    logic          dbe_irq, pass_done, busy;
    logic [1:0]    dbe_addr;

    vx_ecc_scrub_ctrl #(.NUM_LINES(N), .ENCODED_BITS(EB), .INTERVAL(IV), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .scrub_now(scrub_now),
        .cache_busy(cache_busy), .cache_wr_valid(cache_wr_valid), .cache_wr_addr(cache_wr_addr),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dec_in(dec_in), .dec_fixed(dec_fixed), .dec_sbe(dec_sbe), .dec_dbe(dec_dbe),
        .sbe_count(sbe_count), .dbe_count(dbe_count), .dbe_irq(dbe_irq), .dbe_addr(dbe_addr),
        .pass_done(pass_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // toy decoder: bit0 flags a correctable error, bit1 an uncorrectable one; the fix clears both
    assign dec_sbe   = dec_in[0];
    assign dec_dbe   = dec_in[1];
    assign dec_fixed = dec_in & ~EB'(3);

    logic [EB-1:0] mem [N];
    int n_cmp = 0, n_err = 0, cyc = 0, nreads = 0, exp_ptr = 0;
    int exp_sbe = 0, exp_dbe = 0, exp_irq = 0, irq_cnt = 0, pd_cnt = 0, last_dbe = -1;
    bit pending = 0;
    int pend_addr = 0;
    logic [EB-1:0] pend_data = '0, rsp_word = '0, last_rsp = '0;
    bit rsp_pend = 0, chk_dec = 0, rand_mode = 0, force_busy = 0, stall_wr = 0, wr_seen = 0;
    bit hit_sched = 0, armed = 0;
    int rsp_dly = 0, lat_max = 0, hit_line = -1, gap_exp = 0, last_rd = 0;

    task automatic check(input string tag, input logic [EB-1:0] got, input logic [EB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [EB-1:0] rand_word(input int kind);
        logic [EB-1:0] w = '0;
        for (int i = 0; i < 5; i++) w = (w << 32) | EB'($urandom);
        w[1:0] = kind[1:0];
        return w;
    endfunction

    function automatic logic [EB-1:0] fix_of(input logic [EB-1:0] w);
        return {w[EB-1:2], 2'b00};
    endfunction

    function automatic int sat(input int v);
        return v >= CMAX ? CMAX : v + 1;
    endfunction

    task automatic rd_accept();
        logic [EB-1:0] w;
        check("rd_addr", EB'(mem_req_addr), EB'(exp_ptr));
        check("wr_missing", EB'(pending), EB'(0));
        pending = 0;
        check("sbe_count", EB'(sbe_count), EB'(exp_sbe));
        check("dbe_count", EB'(dbe_count), EB'(exp_dbe));
        check("irq_pulses", EB'(irq_cnt), EB'(exp_irq));
        check("pass_pulses", EB'(pd_cnt), EB'(nreads / N));
        if (last_dbe >= 0) check("dbe_addr", EB'(dbe_addr), EB'(last_dbe));
        if (gap_exp > 0 && armed) check("step_gap", EB'(cyc - last_rd), EB'(gap_exp));
        armed = 1;
        last_rd = cyc;
        w = mem[mem_req_addr];
        rsp_word = w;
        rsp_pend = 1;
        rsp_dly = $urandom_range(lat_max, 0);
        if (w[1]) begin
            exp_dbe = sat(exp_dbe);
            exp_irq++;
            last_dbe = int'(mem_req_addr);
        end else if (w[0]) begin
            exp_sbe = sat(exp_sbe);
            pending = 1;
            pend_addr = int'(mem_req_addr);
            pend_data = fix_of(w);
        end
        if (int'(mem_req_addr) == hit_line) hit_sched = 1;
        nreads++;
        exp_ptr = (exp_ptr + 1) % N;
    endtask

    task automatic wr_accept();
        check("wr_expected", EB'(pending), EB'(1));
        check("wr_addr", EB'(mem_req_addr), EB'(pend_addr));
        check("wr_data", mem_req_data, pend_data);
        mem[mem_req_addr] = mem_req_data;
        pending = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_dec) check("dec_in", dec_in, last_rsp);
        chk_dec = 0;
        mem_rsp_valid = 1'b0;
        if (rsp_pend) begin
            if (rsp_dly == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data = rsp_word;
                last_rsp = rsp_word;
                rsp_pend = 0;
                chk_dec = 1;
            end else rsp_dly--;
        end
        if (hit_sched) begin
            cache_busy = 1'b1;
            cache_wr_valid = 1'b1;
            cache_wr_addr = 2'(hit_line);
            hit_sched = 0;
        end else begin
            cache_busy = force_busy || (rand_mode && $urandom_range(3, 0) == 0);
            cache_wr_valid = cache_busy && rand_mode && $urandom_range(2, 0) == 0;
            cache_wr_addr = 2'($urandom);
        end
        mem_req_ready = rand_mode ? ($urandom_range(2, 0) != 0) : 1'b1;
        #1;
        if (stall_wr && mem_req_valid && mem_req_rw) begin
            mem_req_ready = 1'b0;
            wr_seen = 1;
        end
        check("no_req_busy", EB'(mem_req_valid & cache_busy), EB'(0));
        if (dbe_irq) irq_cnt++;
        if (pass_done) pd_cnt++;
        if (cache_wr_valid) begin
            mem[cache_wr_addr] = rand_word(0);
            if (pending && int'(cache_wr_addr) == pend_addr) pending = 0;
        end
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_rw) wr_accept();
            else rd_accept();
        end
        cyc++;
    endtask

    task automatic pulse();
        scrub_now = 1'b1;
        tick();
        scrub_now = 1'b0;
    endtask

    task automatic run_reads(input int n, input int budget);
        int target = nreads + n;
        for (int i = 0; i < budget && nreads < target; i++) tick();
        check("rd_timeout", EB'(nreads >= target), EB'(1));
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        tick();
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", EB'(busy), EB'(0));
    endtask

    task automatic chk_reset();
        check("rst_req", EB'({mem_req_valid, mem_req_rw, mem_req_addr}), EB'(0));
        check("rst_req_data", mem_req_data, EB'(0));
        check("rst_dec_in", dec_in, EB'(0));
        check("rst_counts", EB'({sbe_count, dbe_count}), EB'(0));
        check("rst_dbe", EB'({dbe_irq, dbe_addr}), EB'(0));
        check("rst_flags", EB'({pass_done, busy}), EB'(0));
    endtask

    task automatic model_reset();
        nreads = 0; exp_ptr = 0; exp_sbe = 0; exp_dbe = 0; exp_irq = 0;
        irq_cnt = 0; pd_cnt = 0; last_dbe = -1; pending = 0; rsp_pend = 0;
        chk_dec = 0; hit_sched = 0; armed = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        for (int i = 0; i < N; i++) mem[i] = rand_word(0);
        repeat (3) @(negedge clk);
        chk_reset();
        reset = 1'b0;
        // periodic scrubbing over clean lines: steps spaced by the interval plus step latency
        enable = 1'b1;
        gap_exp = IV + 4;
        run_reads(5, 300);
        gap_exp = 0;
        mem[2] = rand_word(1);
        run_reads(4, 300);
        mem[1] = rand_word(3);
        run_reads(4, 300);
        enable = 1'b0;
        repeat (40) tick();
        // request held off while the cache owns the port
        force_busy = 1;
        pulse();
        repeat (20) tick();
        check("hold_busy", EB'(busy), EB'(1));
        force_busy = 0;
        r = nreads;
        tick();
        check("req_on_drop", EB'(nreads), EB'(r + 1));
        run_idle(300);
        // cache rewrites line 3 while its SBE read is outstanding
        lat_max = 2;
        mem[3] = rand_word(1);
        hit_line = 3;
        pulse();
        run_idle(300);
        hit_line = -1;
        check("stale_sbe_count", EB'(sbe_count), EB'(exp_sbe));
        // randomized contention, latency, errors and cache writes
        rand_mode = 1;
        enable = 1'b1;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) mem[$urandom_range(N - 1, 0)] = rand_word(int'($urandom_range(3, 0)));
            scrub_now = ($urandom_range(199, 0) == 0);
            tick();
        end
        scrub_now = 1'b0;
        rand_mode = 0;
        enable = 1'b0;
        lat_max = 0;
        repeat (150) tick();
        check("drain_wr", EB'(pending), EB'(0));
        check("drain_busy", EB'(busy), EB'(0));
        // forced full pass runs back to back
        for (int i = 0; i < N; i++) mem[i] = rand_word(0);
        if (exp_ptr != 0) begin
            pulse();
            run_idle(200);
        end
        gap_exp = 4;
        armed = 0;
        r = nreads;
        pulse();
        run_idle(200);
        check("pass_len", EB'(nreads - r), EB'(N));
        gap_exp = 0;
        // counter saturation
        repeat (5) begin
            for (int i = 0; i < N; i++) mem[i] = rand_word(1);
            pulse();
            run_idle(200);
        end
        check("sbe_sat", EB'(sbe_count), EB'(CMAX));
        // reset while a write-back is stalled
        mem[0] = rand_word(1);
        stall_wr = 1;
        wr_seen = 0;
        pulse();
        for (int i = 0; i < 50 && !wr_seen; i++) tick();
        check("wr_stall_seen", EB'(wr_seen), EB'(1));
        reset = 1'b1;
        #1;
        model_reset();
        chk_reset();
        stall_wr = 0;
        tick();
        reset = 1'b0;
        pulse();
        run_idle(200);
        check("final_sbe", EB'(sbe_count), EB'(exp_sbe));
        check("final_pass", EB'(pd_cnt), EB'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
